// File: rtl/button_input_controller.sv
// Button front end for the Tetris grid controller: synchronises and debounces
// five raw buttons, turns presses and held-button repeats into pending events,
// and issues one 4-bit command at a time, each held long enough for the grid
// controller's address/data alternation.
module button_input_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [3:0] controller_out,
  output logic       cmd_strobe
);

  localparam int NB = 5;
  localparam int IDX_LEFT   = 0;
  localparam int IDX_RIGHT  = 1;
  localparam int IDX_ROTATE = 2;
  localparam int IDX_DOWN   = 3;
  localparam int IDX_START  = 4;

  // Buttons that generate auto-repeat events while held: DOWN, RIGHT, LEFT.
  localparam logic [NB-1:0] REPEATABLE = 5'b01011;

  localparam logic [19:0] DB_LAST    = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0] DELAY_LAST = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] RATE_LAST  = 25'(REPEAT_RATE - 1);
  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    CMD_NONE   = 4'b0000,
    CMD_LEFT   = 4'b0001,
    CMD_RIGHT  = 4'b0010,
    CMD_ROTATE = 4'b0011,
    CMD_START  = 4'b0100,
    CMD_DOWN   = 4'b0101
  } cmd_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync_a, sync_b;
  logic [NB-1:0] db, db_q;
  logic [19:0]   db_cnt [NB];
  logic [24:0]   hold_cnt [NB];
  logic [NB-1:0] armed;
  logic [NB-1:0] repeat_hit;
  logic [NB-1:0] pend, pend_set, pend_clr;
  logic [NB-1:0] grant;
  cmd_t          grant_code;
  state_t        state, state_d;
  logic          load;
  logic [7:0]    pulse_cnt;
  cmd_t          code_q;

  assign raw = {btn_start, btn_down, btn_rotate, btn_right, btn_left};

  // Two-flop synchroniser per button.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: db flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      db   <= '0;
      db_q <= '0;
      // NOTE: the per-button counter arrays are plain flops and are cleared one by one;
      // a stale count surviving reset would shorten the next debounce.
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < NB; i++) begin
        if (sync_b[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Event detection: a debounced rise, or a hold counter reaching its repeat point.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    repeat_hit = '0;
    for (int i = 0; i < NB; i++) begin
      if (REPEATABLE[i] && db[i] && db_q[i])
        repeat_hit[i] = armed[i] ? (hold_cnt[i] == RATE_LAST) : (hold_cnt[i] == DELAY_LAST);
    end
    pend_set = (db & ~db_q) | repeat_hit;
  end

  // Hold counters: zero at the debounced rise, first repeat after REPEAT_DELAY, then every REPEAT_RATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= '0;
      for (int i = 0; i < NB; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (!(REPEATABLE[i] && db[i] && db_q[i])) begin
          hold_cnt[i] <= '0;
          armed[i]    <= 1'b0;
        end else if (repeat_hit[i]) begin
          hold_cnt[i] <= '0;
          armed[i]    <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + 25'd1;
        end
      end
    end
  end

  // Pending slots: one per button; a same-cycle set beats the issue-clear.
  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= (pend & ~pend_clr) | pend_set;
  end

  // Fixed-priority arbitration: START > ROTATE > DOWN > LEFT > RIGHT.
  always_comb begin
    grant      = '0;
    grant_code = CMD_NONE;
    if (pend[IDX_START]) begin
      grant[IDX_START] = 1'b1;
      grant_code       = CMD_START;
    end else if (pend[IDX_ROTATE]) begin
      grant[IDX_ROTATE] = 1'b1;
      grant_code        = CMD_ROTATE;
    end else if (pend[IDX_DOWN]) begin
      grant[IDX_DOWN] = 1'b1;
      grant_code      = CMD_DOWN;
    end else if (pend[IDX_LEFT]) begin
      grant[IDX_LEFT] = 1'b1;
      grant_code      = CMD_LEFT;
    end else if (pend[IDX_RIGHT]) begin
      grant[IDX_RIGHT] = 1'b1;
      grant_code       = CMD_RIGHT;
    end
  end

  assign pend_clr = load ? grant : '0;

  // Output FSM state register, pulse counter and latched command code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      code_q    <= CMD_NONE;
    end else begin
      state <= state_d;
      if (load) begin
        code_q    <= grant_code;
        pulse_cnt <= '0;
      end else if (state == ISSUE) begin
        pulse_cnt <= pulse_cnt + 8'd1;
      end
    end
  end

  // Next-state logic; the single GAP cycle also serves as the arbitration slot
  // so back-to-back commands are PULSE_CYCLES+1 cycles apart.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (pulse_cnt == PULSE_LAST) state_d = GAP;
      end
      GAP: begin
        if (|pend) begin
          state_d = ISSUE;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: code only while issuing, strobe on its first cycle.
  always_comb begin
    controller_out = CMD_NONE;
    cmd_strobe     = 1'b0;
    if (state == ISSUE) begin
      controller_out = code_q;
      cmd_strobe     = (pulse_cnt == 8'd0);
    end
  end

endmodule

// File: tb/tb_button_input_controller.sv
// Directed bench for button_input_controller with short timing parameters.
// Outputs are recorded each negedge into a per-edge history and compared
// against hand-computed cycle positions relative to each press.
module tb_button_input_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left, btn_right, btn_rotate, btn_down, btn_start;
  logic [3:0] controller_out;
  logic       cmd_strobe;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [3:0] out_hist    [0:4095];
  logic       strobe_hist [0:4095];

  button_input_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_RATE    (8),
    .PULSE_CYCLES   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_rotate    (btn_rotate),
    .btn_down      (btn_down),
    .btn_start     (btn_start),
    .controller_out(controller_out),
    .cmd_strobe    (cmd_strobe)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // History: entry k holds the outputs seen after edge k.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      out_hist[cyc]    <= controller_out;
      strobe_hist[cyc] <= cmd_strobe;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int strobes(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (strobe_hist[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int busy(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (out_hist[k] !== 4'b0000) n++;
    return n;
  endfunction

  int n;
  int starts3 [4];
  logic [3:0] exp4 [10];
  logic [3:0] exp5 [8];

  initial begin
    reset = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0;
    btn_down = 1'b0; btn_start = 1'b0;
    step(3);
    check("reset_out", controller_out, 4'b0000);
    check("reset_strobe", cmd_strobe, 1'b0);
    reset = 1'b0;
    step(2);

    // 1: ROTATE press, latency DEBOUNCE+3, 2-cycle pulse, no repeat while held.
    n = cyc + 1;
    btn_rotate = 1'b1;
    step(14);
    check("rot_before", out_hist[n+6], 4'b0000);
    check("rot_c0", out_hist[n+7], 4'b0011);
    check("rot_c1", out_hist[n+8], 4'b0011);
    check("rot_gap", out_hist[n+9], 4'b0000);
    check("rot_strobe0", strobe_hist[n+7], 1'b1);
    check("rot_strobe1", strobe_hist[n+8], 1'b0);
    step(40);
    check("rot_no_repeat", strobes(n + 9, n + 52), 0);
    btn_rotate = 1'b0;
    step(15);

    // 2: short pulse and bounce are filtered.
    n = cyc + 1;
    btn_left = 1'b1; step(3); btn_left = 1'b0; step(3);
    for (int r = 0; r < 2; r++) begin
      btn_left = 1'b1; step(1); btn_left = 1'b0; step(1);
    end
    step(20);
    check("glitch_strobes", strobes(n, cyc - 1), 0);
    check("glitch_busy", busy(n, cyc - 1), 0);

    // 3: LEFT held -> commands at hold offsets 0, 16, 24, 32.
    n = cyc + 1;
    btn_left = 1'b1;
    step(36);
    btn_left = 1'b0;
    step(50);
    starts3 = '{n + 7, n + 23, n + 31, n + 39};
    check("rep_count", strobes(n, n + 84), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rep%0d_strobe", k), strobe_hist[starts3[k]], 1'b1);
      check($sformatf("rep%0d_c0", k), out_hist[starts3[k]], 4'b0001);
      check($sformatf("rep%0d_c1", k), out_hist[starts3[k]+1], 4'b0001);
      check($sformatf("rep%0d_gap", k), out_hist[starts3[k]+2], 4'b0000);
    end

    // 4: simultaneous START, LEFT, RIGHT -> priority order, single-cycle gaps.
    n = cyc + 1;
    btn_start = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    step(8);
    btn_start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    step(20);
    exp4 = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0};
    for (int k = 0; k < 10; k++)
      check($sformatf("prio_e%0d", k + 6), out_hist[n+6+k], exp4[k]);
    check("prio_strobes", strobes(n, n + 27), 3);

    // 5: DOWN tap released during START's ISSUE is still issued.
    n = cyc + 1;
    btn_start = 1'b1;
    step(2);
    btn_down = 1'b1;
    step(6);
    btn_down = 1'b0;
    step(2);
    btn_start = 1'b0;
    step(20);
    exp5 = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0};
    for (int k = 0; k < 8; k++)
      check($sformatf("tap_e%0d", k + 6), out_hist[n+6+k], exp5[k]);
    check("tap_strobes", strobes(n, n + 28), 2);

    // 6: reset during LEFT's ISSUE aborts it and drops pending RIGHT.
    n = cyc + 1;
    btn_left = 1'b1; btn_right = 1'b1;
    step(8);
    btn_left = 1'b0; btn_right = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(30);
    check("rst_issue", out_hist[n+7], 4'b0001);
    check("rst_issue_strobe", strobe_hist[n+7], 1'b1);
    check("rst_abort", out_hist[n+8], 4'b0000);
    check("rst_abort_strobe", strobe_hist[n+8], 1'b0);
    check("rst_no_right", strobes(n + 8, n + 38), 0);
    check("rst_quiet", busy(n + 8, n + 38), 0);
    n = cyc + 1;
    btn_right = 1'b1;
    step(10);
    btn_right = 1'b0;
    check("post_rst_before", out_hist[n+6], 4'b0000);
    check("post_rst_right", out_hist[n+7], 4'b0010);
    check("post_rst_strobe", strobe_hist[n+7], 1'b1);
    step(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
